// File: rtl/matrix_pkg.sv
// matrix_pkg: shared definitions for the matrix coprocessor operators.
//   N_DEFAULT / W_DEFAULT : default matrix dimension and element width
//   ELEMS                 : element count of a default-sized matrix
//   state_e               : loader state encoding (StLoad, StFull)
//   slot_offset()         : bit offset of element (i,j) in a flattened N*N*W bus
package matrix_pkg;

  localparam int unsigned N_DEFAULT = 3;
  localparam int unsigned W_DEFAULT = 8;
  localparam int unsigned ELEMS     = N_DEFAULT * N_DEFAULT;

  typedef enum logic {
    StLoad = 1'b0,
    StFull = 1'b1
  } state_e;

  // Row-major packing: element (i,j) lives at bits [(i*n+j)*w +: w].
  function automatic int unsigned slot_offset(input int unsigned i, input int unsigned j,
                                              input int unsigned n, input int unsigned w);
    return (i * n + j) * w;
  endfunction

endpackage

// File: rtl/matrix_loader.sv
// matrix_loader: byte-serial matrix input stage. Accepts N*N elements in row-major order,
// one per valid/ready handshake, packs them into a flattened bus and holds the completed
// matrix until the downstream operator consumes it. Frames whose in_last does not coincide
// with the final element are dropped with a one-cycle frame_err pulse.
//   clk         : system clock, rising edge
//   rst         : synchronous active-low reset
//   in_valid    : upstream element present
//   in_ready    : loader can accept an element (registered)
//   in_data     : element value
//   in_last     : final element of a frame
//   matrix_out  : packed matrix, element (i,j) at [(i*N+j)*W +: W]
//   out_valid   : matrix_out holds a complete frame (registered)
//   out_ready   : downstream consumes the matrix
//   frame_err   : one-cycle pulse after a malformed frame ends
//   elem_count  : slot index for the next accepted element
module matrix_loader
  import matrix_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT,
  parameter int unsigned W = W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_data,
  input  logic                     in_last,
  output logic [N*N*W-1:0]         matrix_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     frame_err,
  output logic [$clog2(N*N)-1:0]   elem_count
);

  localparam int unsigned Elems   = N * N;
  localparam int unsigned CntW    = $clog2(Elems);
  localparam int unsigned LastIdx = Elems - 1;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [N*N*W-1:0] matrix_q;
  logic             out_valid_q;
  logic             in_ready_q;
  logic             frame_err_q;

  logic accept;
  logic at_last;

  // in_ready_q is only ever high in StLoad, so it doubles as the state qualifier.
  assign accept  = in_valid && in_ready_q;
  assign at_last = (cnt_q == CntW'(LastIdx));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StLoad;
      cnt_q       <= '0;
      matrix_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        StLoad: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          if (accept) begin
            for (int unsigned i = 0; i < N; i++) begin
              for (int unsigned j = 0; j < N; j++) begin
                if (cnt_q == CntW'(i * N + j)) begin
                  matrix_q[slot_offset(i, j, N, W) +: W] <= in_data;
                end
              end
            end
            if (at_last && in_last) begin
              state_q     <= StFull;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
              cnt_q       <= '0;
            end else if (at_last || in_last) begin
              // Early or missing last: drop the frame and restart at slot 0.
              frame_err_q <= 1'b1;
              cnt_q       <= '0;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        StFull: begin
          if (out_ready) begin
            state_q     <= StLoad;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign frame_err  = frame_err_q;
  assign matrix_out = matrix_q;
  assign elem_count = cnt_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Directed, table-driven bench for matrix_loader at N=3, W=8.
module tb_matrix_loader;

  localparam int unsigned N = 3;
  localparam int unsigned W = 8;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic [71:0] matrix_out;
  logic        out_valid;
  logic        out_ready;
  logic        frame_err;
  logic [3:0]  elem_count;

  matrix_loader #(
    .N(N),
    .W(W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .matrix_out(matrix_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .elem_count(elem_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [3:0] exp_cnt;
    logic       exp_ov;
    logic       exp_err;
  } vec_t;

  vec_t        vecs[36];
  int          checks;
  int          failures;
  logic [71:0] model_mat;
  int          model_idx;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int idx, input logic [7:0] data, input logic last,
                         input logic [3:0] cnt, input logic ov, input logic err);
    vecs[idx].data    = data;
    vecs[idx].last    = last;
    vecs[idx].exp_cnt = cnt;
    vecs[idx].exp_ov  = ov;
    vecs[idx].exp_err = err;
  endtask

  // Apply one element per cycle; in_ready is expected high for every row.
  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      in_valid = 1'b1;
      in_data  = vecs[i].data;
      in_last  = vecs[i].last;
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
      model_mat[model_idx*8 +: 8] = vecs[i].data;
      model_idx = int'(vecs[i].exp_cnt);
      chk($sformatf("vec%0d_cnt", i), 72'(elem_count), 72'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d_ov", i), 72'(out_valid), 72'(vecs[i].exp_ov));
      chk($sformatf("vec%0d_err", i), 72'(frame_err), 72'(vecs[i].exp_err));
      chk($sformatf("vec%0d_rdy", i), 72'(in_ready), 72'(!vecs[i].exp_ov));
      chk($sformatf("vec%0d_mat", i), matrix_out, model_mat);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("consume_ov", 72'(out_valid), 72'(0));
    chk("consume_rdy", 72'(in_ready), 72'(1));
  endtask

  initial begin
    int          e;
    int          frames;
    logic        rdy_before;
    logic        ov_before;
    logic [71:0] build;
    logic [71:0] sb_q[$];
    logic [71:0] held;

    checks    = 0;
    failures  = 0;
    model_mat = '0;
    model_idx = 0;

    // 1..9, last on 9
    for (int k = 0; k < 9; k++)
      set_vec(k, 8'(k + 1), k == 8, (k == 8) ? 4'd0 : 4'(k + 1), k == 8, 1'b0);
    // early last on 4th element
    for (int k = 0; k < 4; k++)
      set_vec(9 + k, 8'(8'h21 + k), k == 3, (k == 3) ? 4'd0 : 4'(k + 1), 1'b0, k == 3);
    // 10..18, last on 18
    for (int k = 0; k < 9; k++)
      set_vec(13 + k, 8'(10 + k), k == 8, (k == 8) ? 4'd0 : 4'(k + 1), k == 8, 1'b0);
    // nine elements, no last
    for (int k = 0; k < 9; k++)
      set_vec(22 + k, 8'(8'h31 + k), 1'b0, (k == 8) ? 4'd0 : 4'(k + 1), 1'b0, k == 8);
    // five elements, interrupted by reset
    for (int k = 0; k < 5; k++)
      set_vec(31 + k, 8'(8'h51 + k), 1'b0, 4'(k + 1), 1'b0, 1'b0);

    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) step();
    chk("rst_mat", matrix_out, 72'(0));
    chk("rst_ov", 72'(out_valid), 72'(0));
    chk("rst_err", 72'(frame_err), 72'(0));
    chk("rst_cnt", 72'(elem_count), 72'(0));
    chk("rst_rdy", 72'(in_ready), 72'(0));
    rst = 1'b1;
    step();
    chk("post_rst_rdy", 72'(in_ready), 72'(1));

    // Basic frame
    run_vecs(0, 8);
    chk("f1_slot00", 72'(matrix_out[7:0]), 72'(1));
    chk("f1_slot11", 72'(matrix_out[39:32]), 72'(5));
    chk("f1_slot22", 72'(matrix_out[71:64]), 72'(9));

    // FULL hold with input noise
    held     = model_mat;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("hold%0d_mat", c), matrix_out, held);
      chk($sformatf("hold%0d_cnt", c), 72'(elem_count), 72'(0));
      chk($sformatf("hold%0d_ov", c), 72'(out_valid), 72'(1));
    end
    in_valid = 1'b0;
    consume();

    // Early last, then a good frame
    run_vecs(9, 12);
    step();
    chk("early_err_pulse_end", 72'(frame_err), 72'(0));
    chk("early_no_ov", 72'(out_valid), 72'(0));
    run_vecs(13, 21);
    chk("f2_slot00", 72'(matrix_out[7:0]), 72'(10));
    chk("f2_slot22", 72'(matrix_out[71:64]), 72'(18));
    consume();

    // Missing last
    run_vecs(22, 30);
    step();
    chk("miss_err_pulse_end", 72'(frame_err), 72'(0));
    chk("miss_no_ov", 72'(out_valid), 72'(0));
    chk("miss_cnt", 72'(elem_count), 72'(0));

    // Reset mid-frame
    run_vecs(31, 35);
    rst = 1'b0;
    step();
    model_mat = '0;
    model_idx = 0;
    chk("midrst_mat", matrix_out, 72'(0));
    chk("midrst_ov", 72'(out_valid), 72'(0));
    chk("midrst_err", 72'(frame_err), 72'(0));
    chk("midrst_cnt", 72'(elem_count), 72'(0));
    chk("midrst_rdy", 72'(in_ready), 72'(0));
    rst = 1'b1;
    step();
    chk("midrst_rdy_back", 72'(in_ready), 72'(1));
    run_vecs(0, 8);
    consume();

    // Back-to-back frames, out_ready held high, random input gaps
    out_ready = 1'b1;
    e         = 0;
    frames    = 0;
    build     = '0;
    for (int cyc = 0; cyc < 400 && frames < 3; cyc++) begin
      in_valid   = (e < 27) && ($urandom_range(0, 3) != 0);
      in_data    = 8'(8'h60 + e);
      in_last    = (e % 9 == 8);
      rdy_before = in_ready;
      ov_before  = out_valid;
      step();
      if (ov_before) chk("b2b_no_accept_full", 72'(rdy_before), 72'(0));
      if (in_valid && rdy_before) begin
        build[(e % 9)*8 +: 8] = in_data;
        if (e % 9 == 8) sb_q.push_back(build);
        e++;
      end
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          chk("b2b_unexpected_frame", 72'(out_valid), 72'(0));
        end else begin
          chk($sformatf("b2b_frame%0d", frames), matrix_out, sb_q.pop_front());
        end
        frames++;
      end
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    chk("b2b_frames_seen", 72'(frames), 72'(3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
